// File: rtl/rf_pkg.sv
// Shared register-file constants and writeback requester indices.
package rf_pkg;
   localparam int RF_DW   = 16;
   localparam int RF_AW   = 3;
   localparam int RF_NREG = 8;
   localparam int RF_NREQ = 3;
   localparam int RF_CW   = 2;

   localparam int REQ_ALU = 0;
   localparam int REQ_MEM = 1;
   localparam int REQ_IO  = 2;
endpackage

// File: rtl/rr_arbiter.sv
// NREQ-wide grant logic: round-robin with a rotating pointer, or fixed
// lowest-index priority when RF_WB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
   parameter int NREQ = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            hold,
   input  logic [NREQ-1:0] valid,
   output logic [NREQ-1:0] grant
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic found;

`ifdef RF_WB_FIXED_PRIO_EN
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst_n;

   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && !hold && valid[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end
`else
   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_nxt;
   logic [PW-1:0] idx;

   function automatic int wrap(input int a);
      return (a >= NREQ) ? a - NREQ : a;
   endfunction

   // Scan from ptr upward; the winner's successor becomes the next pointer.
   always_comb begin
      grant   = '0;
      found   = 1'b0;
      ptr_nxt = ptr;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = PW'(wrap(int'(ptr) + k));
         if (!found && !hold && valid[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
            ptr_nxt    = PW'(wrap(int'(ptr) + k + 1));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) ptr <= '0;
      else        ptr <= ptr_nxt;
   end
`endif
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-bank write-port arbiter with registered write stage and pending
// write scoreboard. RF_WB_FIXED_PRIO_EN selects fixed priority over round-robin.
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int NREQ = RF_NREQ,
   parameter int DW   = RF_DW,
   parameter int AW   = RF_AW,
   parameter int CW   = RF_CW
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wb_hold,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*AW-1:0] req_rd,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic               rsv_valid,
   input  logic [AW-1:0]      rsv_rd,
   output logic               rf_wr_en,
   output logic [AW-1:0]      rf_rd,
   output logic [DW-1:0]      rf_data_in,
   output logic [(1<<AW)-1:0] busy,
   output logic               sb_err
);
   localparam int NREG = 1 << AW;

   logic [AW-1:0] sel_rd;
   logic [DW-1:0] sel_data;
   logic          xfer;
   logic [CW-1:0] cnt     [NREG];
   logic [CW-1:0] cnt_nxt [NREG];
   logic          err_nxt;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .hold  (wb_hold),
      .valid (req_valid),
      .grant (req_ready)
   );

   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i]) begin
            sel_rd   = req_rd[i*AW +: AW];
            sel_data = req_data[i*DW +: DW];
         end
      end
   end

   assign xfer = |(req_valid & req_ready);

   // Address and data hold their last value when no write is in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rf_wr_en   <= 1'b0;
         rf_rd      <= '0;
         rf_data_in <= '0;
      end else begin
         rf_wr_en <= xfer;
         if (xfer) begin
            rf_rd      <= sel_rd;
            rf_data_in <= sel_data;
         end
      end
   end

   // Saturating pending counters; a simultaneous reserve and commit cancel.
   always_comb begin
      err_nxt = sb_err;
      for (int r = 0; r < NREG; r++) begin
         cnt_nxt[r] = cnt[r];
         case ({rsv_valid && (rsv_rd == AW'(r)), rf_wr_en && (rf_rd == AW'(r))})
            2'b10: begin
               if (cnt[r] == {CW{1'b1}}) err_nxt = 1'b1;
               else                      cnt_nxt[r] = cnt[r] + CW'(1);
            end
            2'b01: begin
               if (cnt[r] == '0) err_nxt = 1'b1;
               else              cnt_nxt[r] = cnt[r] - CW'(1);
            end
            default: cnt_nxt[r] = cnt[r];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) cnt[r] <= '0;
         sb_err <= 1'b0;
      end else begin
         for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
         sb_err <= err_nxt;
      end
   end

   always_comb begin
      for (int r = 0; r < NREG; r++) busy[r] = |cnt[r];
   end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus random traffic against a
// queue-free behavioural model of grant order, write stage and pending counts.
module tb_rf_wb_arbiter;
   import rf_pkg::*;

   localparam int NREQ = 3;
   localparam int DW   = 16;
   localparam int AW   = 3;
   localparam int CW   = 2;
   localparam int NREG = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              wb_hold;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*AW-1:0] req_rd;
   logic [NREQ*DW-1:0] req_data;
   logic              rsv_valid;
   logic [AW-1:0]     rsv_rd;
   logic              rf_wr_en;
   logic [AW-1:0]     rf_rd;
   logic [DW-1:0]     rf_data_in;
   logic [NREG-1:0]   busy;
   logic              sb_err;

   always #5 clk = ~clk;

   rf_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .CW(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wb_hold    (wb_hold),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_rd     (req_rd),
      .req_data   (req_data),
      .rsv_valid  (rsv_valid),
      .rsv_rd     (rsv_rd),
      .rf_wr_en   (rf_wr_en),
      .rf_rd      (rf_rd),
      .rf_data_in (rf_data_in),
      .busy       (busy),
      .sb_err     (sb_err)
   );

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   int m_ptr = 0;
   int m_cnt [NREG];
   int m_win = -1;
   int m_rd = 0;
   int m_data = 0;
   bit m_wr_en = 1'b0;
   bit m_err = 1'b0;
   bit pend [NREQ];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int model_winner();
      if (wb_hold) return -1;
      for (int k = 0; k < NREQ; k++) begin
         if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [NREG-1:0] model_busy();
      logic [NREG-1:0] b;
      for (int r = 0; r < NREG; r++) b[r] = (m_cnt[r] != 0);
      return b;
   endfunction

   task automatic model_commit();
      bit inc, dec;
      if (!rst_n) begin
         m_ptr = 0; m_wr_en = 0; m_rd = 0; m_data = 0; m_err = 0;
         for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
         return;
      end
      for (int r = 0; r < NREG; r++) begin
         inc = rsv_valid && (int'(rsv_rd) == r);
         dec = m_wr_en && (m_rd == r);
         if (inc && !dec) begin
            if (m_cnt[r] == (1 << CW) - 1) m_err = 1;
            else m_cnt[r]++;
         end else if (dec && !inc) begin
            if (m_cnt[r] == 0) m_err = 1;
            else m_cnt[r]--;
         end
      end
      m_wr_en = (m_win >= 0);
      if (m_win >= 0) begin
         m_rd   = int'(req_rd[m_win*AW +: AW]);
         m_data = int'(req_data[m_win*DW +: DW]);
`ifndef RF_WB_FIXED_PRIO_EN
         m_ptr  = (m_win + 1) % NREQ;
`endif
      end
   endtask

   // One clock: check grant before the edge, advance model, check registered outputs.
   task automatic step();
      logic [NREQ-1:0] exp_ready;
      #1;
      m_win = model_winner();
      exp_ready = (m_win >= 0) ? NREQ'(1 << m_win) : '0;
      chk("req_ready", req_ready, exp_ready);
      @(posedge clk);
      model_commit();
      #1;
      chk("rf_wr_en", rf_wr_en, m_wr_en);
      chk("rf_rd", rf_rd, m_rd);
      chk("rf_data_in", rf_data_in, m_data);
      chk("busy", busy, model_busy());
      chk("sb_err", sb_err, m_err);
      for (int i = 0; i < NREQ; i++) if (m_win == i) pend[i] = 0;
   endtask

   task automatic set_req(input int i, input bit v, input int rd, input int data);
      req_valid[i]         = v;
      req_rd[i*AW +: AW]   = AW'(rd);
      req_data[i*DW +: DW] = DW'(data);
   endtask

   task automatic idle();
      req_valid = '0;
      wb_hold   = 1'b0;
      rsv_valid = 1'b0;
      rsv_rd    = '0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      int rds [3];
      rds = '{1, 2, 4};
      for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
      for (int i = 0; i < NREQ; i++) pend[i] = 0;
      req_rd = '0;
      req_data = '0;
      idle();
      rst_n = 1'b0;
      step();
      step();
      chk("rst_busy", busy, 0);
      chk("rst_err", sb_err, 0);
      chk("rst_wr_en", rf_wr_en, 0);
      rst_n = 1'b1;

      // reset arriving while a captured write is still uncommitted
      set_req(REQ_ALU, 1, 3, 'h00AA);
      step();
      chk("mw_captured", rf_wr_en, 1);
      chk("mw_data", rf_data_in, 'h00AA);
      set_req(REQ_ALU, 0, 3, 'h00AA);
      rst_n = 1'b0;
      step();
      chk("mw_wr_en", rf_wr_en, 0);
      chk("mw_busy", busy, 0);
      chk("mw_err", sb_err, 0);
      rst_n = 1'b1;

      // full contention
      set_req(REQ_ALU, 1, 1, 'h1111);
      set_req(REQ_MEM, 1, 2, 'h2222);
      set_req(REQ_IO,  1, 4, 'h4444);
      for (int c = 0; c < 6; c++) begin
         step();
         chk("cont_wr_en", rf_wr_en, 1);
`ifndef RF_WB_FIXED_PRIO_EN
         chk("cont_rd", rf_rd, rds[c % 3]);
`endif
      end

      // hold, then release
      set_req(REQ_IO, 0, 4, 'h4444);
      wb_hold = 1'b1;
      step();
      chk("hold_wr_en", rf_wr_en, 0);
      wb_hold = 1'b0;
      step();
      chk("release_rd", rf_rd, 1);
      idle();
      step();
      do_reset();

      // scoreboard counting
      rsv_valid = 1'b1; rsv_rd = 3'd5;
      step(); step();
      rsv_valid = 1'b0;
      set_req(REQ_ALU, 1, 5, 'h0055);
      step();
      set_req(REQ_ALU, 0, 5, 'h0055);
      step();
      chk("sb_one_left", busy[5], 1);
      set_req(REQ_ALU, 1, 5, 'h0056);
      step();
      set_req(REQ_ALU, 0, 5, 'h0056);
      step();
      chk("sb_drained", busy[5], 0);
      rsv_valid = 1'b1;
      step();
      rsv_valid = 1'b0;
      set_req(REQ_ALU, 1, 5, 'h0057);
      step();
      set_req(REQ_ALU, 0, 5, 'h0057);
      rsv_valid = 1'b1;
      step();
      rsv_valid = 1'b0;
      chk("sb_same_cycle", busy[5], 1);
      chk("sb_no_err", sb_err, 0);

      // underflow then overflow
      set_req(REQ_ALU, 1, 6, 'h0066);
      step();
      set_req(REQ_ALU, 0, 6, 'h0066);
      step();
      chk("underflow_err", sb_err, 1);
      chk("underflow_busy", busy[6], 0);
      do_reset();
      rsv_valid = 1'b1; rsv_rd = 3'd7;
      for (int k = 0; k < 4; k++) step();
      rsv_valid = 1'b0;
      chk("overflow_busy", busy[7], 1);
      chk("overflow_err", sb_err, 1);
      do_reset();

`ifdef RF_WB_FIXED_PRIO_EN
      set_req(REQ_ALU, 1, 1, 'h0A0A);
      set_req(REQ_IO,  1, 2, 'h0C0C);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("fixed_rd", rf_rd, 1);
      end
      idle();
      step();
`endif

      // random traffic
      idle();
      for (int i = 0; i < NREQ; i++) pend[i] = 0;
      for (int c = 0; c < 3000; c++) begin
         rst_n   = ($urandom_range(99) != 0);
         wb_hold = ($urandom_range(9) == 0);
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(9) < 4) begin
               pend[i] = 1;
               req_rd[i*AW +: AW]   = AW'($urandom);
               req_data[i*DW +: DW] = DW'($urandom);
            end
            req_valid[i] = pend[i];
         end
         rsv_valid = ($urandom_range(9) < 3);
         rsv_rd    = AW'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
